alu_mc: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle 32-bit datapath ALU.
- Adds the following:
  - configurable width;
  - logical and arithmetic right shifts;
  - an iterative shift-add multiplier;
  - signed overflow;
  - valid/ready handshakes on both sides, so the block can stall a multi-cycle pipeline stage.
- Sits in the execute stage; registered result.

---
 rtl/alu_mc.sv | 154 +++++++++++++++
 tb/tb_alu_mc.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Purpose: parametrised execute-stage ALU with shifts, signed overflow and an iterative shift-add multiplier.
// Latency: 1 cycle for logic/arith/shift ops; WIDTH+1 cycles from accept to out_valid for MUL.
// Backpressure: in_ready drops while the FSM is multiplying or a result is held unconsumed (out_valid & !out_ready).
module alu_mc #(
    parameter int WIDTH  = 32,
    parameter int SHW    = $clog2(WIDTH),
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       f,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             ltez,
    output logic             overflow,
    output logic             busy
);

    // Counter must be able to hold WIDTH itself: it parks there once the multiply is done.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(WIDTH);

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] bout, sum, res;
    logic [WIDTH-1:0] mcand, mplier, acc;
    logic [CW-1:0]    cnt;
    logic             res_sign, res_ovf;
    logic             out_free, accept, is_mul;
    logic             ld_alu, ld_mul, mul_start, mul_step;

    // The output slot is free when empty or being drained on this edge.
    assign out_free = !out_valid || out_ready;
    assign in_ready = (state == IDLE) && out_free;
    assign accept   = in_valid && in_ready;
    assign is_mul   = (MUL_EN != 0) && (f[2:0] == 3'b111);
    // Busy covers only the iterating cycles, not a completed multiply waiting for the output slot.
    assign busy     = (state == MUL) && (cnt != CNT_DONE);

    // Operand decode and single-cycle function select, with the flag sources for each op.
    always_comb begin
        bout     = f[3] ? ~b : b;
        sum      = a + bout + {{(WIDTH-1){1'b0}}, f[3]};
        res      = '0;
        res_ovf  = 1'b0;
        case (f[2:0])
            3'b000: res = a & bout;
            3'b001: res = a | bout;
            3'b010: res = sum;
            3'b011: res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1]};
            3'b100: res = bout << shamt;
            3'b101: res = bout >> shamt;
            3'b110: res = $signed(bout) >>> shamt;
            default: res = 'x;   // multiplier absent: result is don't-care
        endcase
        if (f[2:1] == 2'b01) begin
            // SLT's result bit is not its sign; both add-type ops take sign from the adder.
            res_sign = sum[WIDTH-1];
            res_ovf  = (a[WIDTH-1] == bout[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end else begin
            res_sign = res[WIDTH-1];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state and load strobes; a finished multiply waits in MUL until the output slot frees.
    always_comb begin
        state_n   = state;
        ld_alu    = 1'b0;
        ld_mul    = 1'b0;
        mul_start = 1'b0;
        mul_step  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        mul_start = 1'b1;
                        state_n   = MUL;
                    end else begin
                        ld_alu = 1'b1;
                    end
                end
            end
            MUL: begin
                if (cnt != CNT_DONE) begin
                    mul_step = 1'b1;
                end else if (out_free) begin
                    ld_mul  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Shift-add multiplier datapath: one partial product per cycle, fixed WIDTH iterations.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (mul_start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if (mul_step) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
        end
    end

    // Result/flag registers and out_valid; the bundle only changes on a load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y         <= '0;
            zero      <= 1'b0;
            ltez      <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (ld_alu) begin
                y        <= res;
                zero     <= (res == '0);
                ltez     <= (res == '0) || res_sign;
                overflow <= res_ovf;
            end else if (ld_mul) begin
                y        <= acc;
                zero     <= (acc == '0);
                ltez     <= (acc == '0) || acc[WIDTH-1];
                overflow <= 1'b0;
            end
            if (ld_alu || ld_mul) out_valid <= 1'b1;
            else if (out_ready)   out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Purpose: scoreboard bench for alu_mc at WIDTH=32 (directed + random) and WIDTH=16 (random).
// Latency: expected results queued at accept, compared whenever a result is transferred.
// Backpressure: out_ready is held low or randomised to exercise stalls and drains.
module tb_alu_mc;

    typedef struct packed {
        logic [31:0] y;
        logic        zero;
        logic        ltez;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] a = '0, b = '0, y;
    logic [3:0]  f = '0;
    logic [4:0]  shamt = '0;
    logic        out_valid, out_ready = 1'b1;
    logic        zero, ltez, overflow, busy;

    logic        reset16 = 1'b1;
    logic        in_valid16 = 1'b0, in_ready16;
    logic [15:0] a16 = '0, b16 = '0, y16;
    logic [3:0]  f16 = '0;
    logic [3:0]  shamt16 = '0;
    logic        out_valid16, out_ready16 = 1'b1;
    logic        zero16, ltez16, ovf16, busy16;
    logic        took16 = 1'b0;
    bit          done16 = 1'b0;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t q32[$];
    exp_t q16[$];

    alu_mc #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .f(f), .shamt(shamt), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .zero(zero), .ltez(ltez), .overflow(overflow), .busy(busy)
    );

    alu_mc #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset16), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .f(f16), .shamt(shamt16), .out_valid(out_valid16), .out_ready(out_ready16),
        .y(y16), .zero(zero16), .ltez(ltez16), .overflow(ovf16), .busy(busy16)
    );

    always #5 clk = ~clk;

    // Interpret a w-bit pattern as a signed integer.
    function automatic longint sext(longint unsigned x, int w);
        if (((x >> (w - 1)) & 64'd1) != 0) return longint'(x) - (longint'(1) <<< w);
        return longint'(x);
    endfunction

    // Reference model: plain integer arithmetic at width w.
    function automatic exp_t model(int w, logic [31:0] av, logic [31:0] bv, logic [3:0] fv, int sh);
        longint unsigned mask, aa, bb, bo, sum, r;
        longint          tru, lim;
        logic            sign, ovf;
        exp_t            e;
        mask = (64'd1 << w) - 64'd1;
        aa   = 64'(av) & mask;
        bb   = 64'(bv) & mask;
        bo   = fv[3] ? (~bb & mask) : bb;
        sum  = (aa + bo + 64'(fv[3])) & mask;
        case (fv[2:0])
            3'd0: r = aa & bo;
            3'd1: r = aa | bo;
            3'd2: r = sum;
            3'd3: r = (sum >> (w - 1)) & 64'd1;
            3'd4: r = (bo << sh) & mask;
            3'd5: r = bo >> sh;
            3'd6: r = longint'(sext(bo, w) >>> sh) & mask;
            default: r = (aa * bb) & mask;
        endcase
        ovf = 1'b0;
        if (fv[2:1] == 2'b01) begin
            sign = ((sum >> (w - 1)) & 64'd1) != 0;
            tru  = sext(aa, w) + sext(bo, w) + longint'(fv[3]);
            lim  = longint'(1) <<< (w - 1);
            ovf  = (tru > lim - 1) || (tru < -lim);
        end else begin
            sign = ((r >> (w - 1)) & 64'd1) != 0;
        end
        e.y    = r[31:0];
        e.zero = (r == 0);
        e.ltez = (r == 0) || sign;
        e.ovf  = ovf;
        return e;
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one bundle and hold it until accepted (bounded).
    task automatic send32(logic [31:0] av, logic [31:0] bv, logic [3:0] fv, logic [4:0] sv);
        int n = 0;
        bit ok = 1'b0;
        in_valid = 1'b1; a = av; b = bv; f = fv; shamt = sv;
        while (!ok && n < 300) begin
            @(negedge clk);
            n++;
            if (in_ready) ok = 1'b1;
        end
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected accept", n);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain32();
        int n = 0;
        while (q32.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        check("drain32_left", 64'(q32.size()), 64'd0);
    endtask

    // WIDTH=32 scoreboard: pop on a transfer, then push on an accept.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (q32.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_out32: got y=%h expected no result", y);
                end else begin
                    e = q32.pop_front();
                    check("result32 {y,zero,ltez,ovf}", 64'({y, zero, ltez, overflow}), 64'(e));
                end
            end
            if (in_valid && in_ready) q32.push_back(model(32, a, b, f, int'(shamt)));
        end
    end

    // WIDTH=16 scoreboard.
    always @(negedge clk) begin
        exp_t e;
        took16 = 1'b0;
        if (!reset16) begin
            if (out_valid16 && out_ready16) begin
                if (q16.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_out16: got y=%h expected no result", y16);
                end else begin
                    e = q16.pop_front();
                    check("result16 {y,zero,ltez,ovf}", 64'({y16, zero16, ltez16, ovf16}),
                          64'({e.y[15:0], e.zero, e.ltez, e.ovf}));
                end
            end
            if (in_valid16 && in_ready16) begin
                q16.push_back(model(16, 32'(a16), 32'(b16), f16, int'(shamt16)));
                took16 = 1'b1;
            end
        end
    end

    // WIDTH=16 random stream with random in_valid/out_ready; bundle held until taken.
    initial begin
        int n;
        wait (!reset16);
        for (int c = 0; c < 1500; c++) begin
            tick();
            if (!in_valid16 || took16) begin
                a16 = 16'($urandom);
                b16 = ($urandom_range(0, 7) == 0) ? a16 : 16'($urandom);
                f16 = 4'($urandom_range(0, 15));
                if (f16[2:0] == 3'b111 && $urandom_range(0, 2) != 0) f16[2:0] = 3'b010;
                shamt16 = 4'($urandom_range(0, 15));
                in_valid16 = ($urandom_range(0, 2) != 0);
            end
            out_ready16 = ($urandom_range(0, 3) != 0);
        end
        while (in_valid16 && !took16) tick();
        in_valid16  = 1'b0;
        out_ready16 = 1'b1;
        n = 0;
        while (q16.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain16_left", 64'(q16.size()), 64'd0);
        done16 = 1'b1;
    end

    // WIDTH=32 directed sequence followed by a random stream.
    initial begin
        int  n, nbusy;
        time t0;
        bit  rnd_on;
        logic [31:0] ra, rb;
        logic [3:0]  rf;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        reset16 = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_y", 64'(y), 64'd0);
        check("rst_flags {zero,ltez,ovf,busy}", 64'({zero, ltez, overflow, busy}), 64'd0);
        tick();

        send32(32'h7FFF_FFFF, 32'd1, 4'b0010, 5'd0);
        @(negedge clk);
        check("alu_latency_valid", 64'(out_valid), 64'd1);
        tick();
        send32(32'd5, 32'd5, 4'b1010, 5'd0);
        send32(32'hFFFF_FFFD, 32'd2, 4'b1011, 5'd0);
        send32(32'd0, 32'h8000_0001, 4'b0100, 5'd4);
        send32(32'd0, 32'h8000_0001, 4'b0101, 5'd4);
        send32(32'd0, 32'h8000_0001, 4'b0110, 5'd4);
        send32(32'd0, 32'h1234_A5A5, 4'b1110, 5'd0);
        send32(32'h8000_0000, 32'd1, 4'b1010, 5'd0);
        drain32();

        send32(32'h0001_0003, 32'h0000_0005, 4'b0111, 5'd0);
        n = 0; nbusy = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (busy) nbusy++;
            if (out_valid) break;
        end
        check("mul_latency", 64'(n - 1), 64'd33);
        check("mul_busy_cycles", 64'(nbusy), 64'd32);
        tick();
        send32(32'hFFFF_FFFF, 32'd2, 4'b1111, 5'd0);
        send32(32'h0001_0000, 32'h0001_0000, 4'b0111, 5'd0);
        drain32();

        // Backpressure: first op stalls the output, second must wait.
        out_ready = 1'b0;
        send32(32'hF0F0_1234, 32'h0FF0_FFFF, 4'b0000, 5'd0);
        in_valid = 1'b1; a = 32'h1111_0000; b = 32'h0000_2222; f = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
        end
        tick();
        out_ready = 1'b1;
        t0 = $time;
        send32(32'h1111_0000, 32'h0000_2222, 4'b0001, 5'd0);
        send32(32'hAAAA_AAAA, 32'h5555_5555, 4'b1000, 5'd0);
        send32(32'h0000_00FF, 32'h0000_0F00, 4'b1001, 5'd0);
        check("b2b_cycles", 64'(($time - t0) / 10), 64'd3);
        drain32();

        // Reset in the middle of a multiply discards it.
        send32(32'h1234_5678, 32'h9ABC_DEF1, 4'b0111, 5'd0);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midmul_rst_busy", 64'(busy), 64'd0);
        check("midmul_rst_out_valid", 64'(out_valid), 64'd0);
        q32.delete();
        tick();
        reset = 1'b0;
        tick();
        send32(32'd3, 32'd4, 4'b0010, 5'd0);
        drain32();

        // Random stream with random out_ready.
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    tick();
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int i = 0; i < 300; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    ra = $urandom;
                    rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
                    rf = 4'($urandom_range(0, 15));
                    if (rf[2:0] == 3'b111 && $urandom_range(0, 3) != 0) rf[2:0] = 3'b010;
                    send32(ra, rb, rf, 5'($urandom_range(0, 31)));
                end
                rnd_on = 1'b0;
            end
        join
        out_ready = 1'b1;
        drain32();

        n = 0;
        while (!done16 && n < 5000) begin
            tick();
            n++;
        end
        check("w16_done", 64'(done16), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
